crt_row_fetch: RTL and testbench
================================

# crt_row_fetch

Display-side DMA row fetcher for the CRT path. It raises a DMA request toward the K580VT57 display channel and accepts one byte per DMA write cycle (DACK plus IOWR). Each byte lands in a double-buffered 80-byte row store, and a complete row is handed to the character generator on each row strobe. It paces requests with a programmable burst count and burst spacing, and flags underrun when a row is not ready in time.

## Interface
- `MAXCOL`, default 80: row store depth per bank.
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `ce`, in, 1: character-clock enable. Paces the burst-space counter only.
- `enable`, in, 1: level. 0 aborts fetch and holds IDLE.
- `frame_start`, in, 1: one-clk pulse. Restarts the fill sequence for a new frame.
- `row_next`, in, 1: one-clk pulse from the display timing at each row start.
- `chars`, in, 7: characters per row, 1..80. 0 is treated as 1; values above 80 are clamped to 80.
- `burst_cnt`, in, 2: bytes per burst, encoded 00=1, 01=2, 10=4, 11=8.
- `burst_space`, in, 3: gap between bursts in ce ticks, computed as 8·n−1 (0 means no gap).
- `dack`, in, 1: DMA acknowledge for this channel.
- `iowe_n`, in, 1: DMA I/O write strobe, active low.
- `idata`, in, 8: DMA data bus.
- `drq`, out, 1: DMA request.
- `rd_addr`, in, 7: display read column.
- `rd_data`, out, 8: registered byte from the display bank; 1-clk latency.
- `row_valid`, out, 1: the display bank holds a complete row.
- `underrun`, out, 1: sticky; cleared by `frame_start` or `reset`.

## Operation
- There are two banks. `fbank` is the bank being filled; the display bank is `~fbank`. `full` means `fbank` is complete.
- FSM states are IDLE, REQ, ACK, SPACE and FULL.
- **IDLE**:
  - `drq`=0.
  - `frame_start` with `enable`=1 → REQ, with `col`=0, `bcnt`=0, `full`=0, `row_valid`=0, `underrun`=0.
- **REQ**:
  - `drq`=1.
  - First clk with `dack`=1 and `iowe_n`=0 → ACK. `drq` drops on the next edge so the DMA leaves T2.
- **ACK**:
  - `drq`=0. While `iowe_n`=0, sample `idata` every clk.
  - On the `iowe_n` 0→1 edge, commit the last sample to `fbank[col]`, then `col`++ and `bcnt`++.
  - If `col`==`chars` → FULL.
  - Otherwise, if `bcnt`==burst length: set `bcnt`=0, load the space counter and → SPACE. If the gap is 0, → REQ.
  - Otherwise → REQ.
- **SPACE**:
  - `drq`=0. The counter decrements on `ce`; at 0 → REQ.
- **FULL**:
  - `drq`=0, `full`=1. Waits for `row_next`.
- **`row_next`, any state except IDLE**:
  - If `full`: toggle `fbank`, set `row_valid`=1, clear `full`, `col` and `bcnt` → REQ.
  - If not full: set `underrun`=1 and `row_valid`=0, and keep filling the same bank. A later `row_next` with `full` swaps normally.
- **Display read**: `rd_data` is `bank[~fbank][rd_addr]`. When `row_valid`=0, or `rd_addr` ≥ `chars`, the output is 0x00.
- **Stray writes**: a write with `dack`=0, or a write arriving while not in REQ/ACK, is ignored.
- **`enable`=0** → IDLE, `drq`=0 within 1 clk. Bank contents are kept; `row_valid` is unchanged.
- **`frame_start` outside IDLE**: restarts as from IDLE and discards the partial fill.
- **Counter widths**:
  - `col`: 7 bits.
  - `bcnt`: 4 bits.
  - Space counter: 6 bits.
  - Row store: 2×`MAXCOL`×8, inferred RAM.

## Timing
- Reset values: `drq`=0, `row_valid`=0, `underrun`=0, `rd_data`=0x00, FSM=IDLE, `fbank`=0.
- `frame_start` → `drq`=1 on the next clk edge.
- `dack`&~`iowe_n` seen → `drq`=0 one clk later. `drq` must never stay high across a completed write.
- The commit happens on the clk following the `iowe_n` rising edge. `drq` reasserts on that same edge when in-burst.
- Simultaneous events:
  - `row_next` and the final commit in the same clk: the commit wins first, so `full` is treated as 1 and the swap happens that clk.
  - `frame_start` and `row_next` together: `frame_start` wins.
- Burst gap: (8·n−1) `ce` ticks from the last commit to `drq`=1, ±1 clk.

## Structure
- The shared CRT package holds:
  - the FSM state enum;
  - `MAXCOL`;
  - the burst-length decode function (2 bits → 1/2/4/8);
  - the space decode function (3 bits → 8n−1).
- One sub-module, `crt_row_ram`: a dual-bank 8-bit RAM with one write port and one registered read port, bank-select bit as the address MSB.

## Test plan
- **Single-byte bursts**: reset; `chars`=4, `burst_cnt`=00, `burst_space`=0; `frame_start`; DMA writes 0x41..0x44 → exactly 4 `drq` pulses, then FULL. `row_next` → `row_valid`=1; reads at `rd_addr` 0..3 return 0x41..0x44 and `rd_addr`=4 returns 0x00.
- **Burst spacing**: `chars`=16, `burst_cnt`=10, `burst_space`=001 → 4 writes, then `drq` low for 7 `ce` ticks, then `drq`=1; 4 bursts total.
- **Underrun**: `chars`=80; `row_next` after 10 bytes → `underrun`=1, `row_valid`=0. Complete 80 bytes, then `row_next` → `row_valid`=1 with `underrun` still 1. `frame_start` clears it.
- **Double buffering**: fill row A (0x10..), swap, fill row B (0x20..) while reading A → A is unchanged until the next `row_next`, then `rd_data` shows B.
- **Stray writes and clamping**: a write with `dack`=0 leaves `col` unchanged. `chars`=100 → FULL after 80 bytes.
- **Abort and reset**: `enable`=0 mid-burst → `drq`=0 within 1 clk. `reset` mid-ACK → all outputs return to reset values next clk.

Source files
------------

// File: rtl/crt_row_fetch_pkg.sv
// Shared CRT row-fetch definitions: FSM states, row depth and the
// burst-length / burst-gap decoders used by the DMA pacing logic.
package crt_row_fetch_pkg;

  localparam int CRT_MAXCOL = 80;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    ACK   = 3'd2,
    SPACE = 3'd3,
    FULL  = 3'd4
  } fetch_state_t;

  // 00/01/10/11 -> 1/2/4/8 bytes per burst
  function automatic logic [3:0] burst_len(input logic [1:0] code);
    return 4'd1 << code;
  endfunction

  // gap in ce ticks: 8n-1, zero means back-to-back bursts
  function automatic logic [5:0] space_len(input logic [2:0] n);
    return (n == 3'd0) ? 6'd0 : ({n, 3'b000} - 6'd1);
  endfunction

endpackage

// File: rtl/crt_row_ram.sv
// Dual-bank row store: one write port, one registered read port.
// The bank bit is the outer (most significant) address dimension.
module crt_row_ram #(
  parameter int DEPTH = 80
) (
  input  logic       clk,
  input  logic       we,
  input  logic       wbank,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic       rbank,
  input  logic [6:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [2][DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wbank][waddr] <= wdata;
    rdata <= mem[rbank][raddr];
  end

endmodule

// File: rtl/crt_row_fetch.sv
// CRT display row fetcher: paces DMA requests in bursts, fills one bank of
// the row store while the other is shown, swaps banks on each row strobe.
module crt_row_fetch
  import crt_row_fetch_pkg::*;
#(
  parameter int MAXCOL = CRT_MAXCOL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       enable,
  input  logic       frame_start,
  input  logic       row_next,
  input  logic [6:0] chars,
  input  logic [1:0] burst_cnt,
  input  logic [2:0] burst_space,
  input  logic       dack,
  input  logic       iowe_n,
  input  logic [7:0] idata,
  output logic       drq,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       row_valid,
  output logic       underrun
);

  fetch_state_t state, state_d;
  logic       fbank, full, rd_ok;
  logic [6:0] col, chars_eff;
  logic [3:0] bcnt, blen;
  logic [5:0] spc, gap;
  logic [7:0] sample, ram_q;
  logic       wr_hit, bend, commit, last, swap, starve;

  assign chars_eff = (chars == 7'd0)        ? 7'd1 :
                     (chars > 7'(MAXCOL))   ? 7'(MAXCOL) : chars;
  assign blen   = burst_len(burst_cnt);
  assign gap    = space_len(burst_space);
  assign wr_hit = dack && !iowe_n;
  assign bend   = (bcnt + 4'd1) == blen;
  assign full   = (state == FULL);
  assign drq    = (state == REQ);

  always_comb begin
    state_d = state;
    commit  = 1'b0;
    last    = 1'b0;
    swap    = 1'b0;
    starve  = 1'b0;
    case (state)
      IDLE:  ;
      REQ:   if (wr_hit) state_d = ACK;
      ACK: begin
        // first clk with the strobe released commits the last sampled byte
        if (iowe_n) begin
          commit = 1'b1;
          if (7'(col + 7'd1) >= chars_eff) begin
            last    = 1'b1;
            state_d = FULL;
          end else if (bend && gap != 6'd0) begin
            state_d = SPACE;
          end else begin
            state_d = REQ;
          end
        end
      end
      SPACE: if (ce && spc <= 6'd1) state_d = REQ;
      FULL:  ;
      default: state_d = IDLE;
    endcase
    // a commit completing the row counts as full for a coincident row strobe
    if (row_next && state != IDLE) begin
      if (full || last) begin
        swap    = 1'b1;
        state_d = REQ;
      end else begin
        starve  = 1'b1;
      end
    end
    if (frame_start) begin
      state_d = REQ;
      commit  = 1'b0;
      swap    = 1'b0;
      starve  = 1'b0;
    end
    if (!enable) begin
      state_d = IDLE;
      commit  = 1'b0;
      swap    = 1'b0;
      starve  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fbank     <= 1'b0;
      col       <= 7'd0;
      bcnt      <= 4'd0;
      spc       <= 6'd0;
      sample    <= 8'h00;
      row_valid <= 1'b0;
      underrun  <= 1'b0;
      rd_ok     <= 1'b0;
    end else begin
      state <= state_d;
      rd_ok <= row_valid && (rd_addr < chars_eff);
      if ((state == REQ || state == ACK) && wr_hit) sample <= idata;
      if (state == SPACE && ce) spc <= spc - 6'd1;
      if (commit) begin
        col  <= col + 7'd1;
        bcnt <= bend ? 4'd0 : bcnt + 4'd1;
        if (bend) spc <= gap;
      end
      if (starve) begin
        underrun  <= 1'b1;
        row_valid <= 1'b0;
      end
      if (swap) begin
        fbank     <= ~fbank;
        row_valid <= 1'b1;
        col       <= 7'd0;
        bcnt      <= 4'd0;
      end
      if (frame_start && enable) begin
        col       <= 7'd0;
        bcnt      <= 4'd0;
        row_valid <= 1'b0;
        underrun  <= 1'b0;
      end
    end
  end

  crt_row_ram #(.DEPTH(MAXCOL)) u_ram (
    .clk   (clk),
    .we    (commit),
    .wbank (fbank),
    .waddr (col),
    .wdata (sample),
    .rbank (~fbank),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  assign rd_data = rd_ok ? ram_q : 8'h00;

endmodule

// File: tb/tb_crt_row_fetch.sv
// Randomized bench for crt_row_fetch against a row-level queue model.
module tb_crt_row_fetch;

  logic       clk = 1'b0;
  logic       reset, ce, enable, frame_start, row_next;
  logic [6:0] chars, rd_addr;
  logic [1:0] burst_cnt;
  logic [2:0] burst_space;
  logic       dack, iowe_n, drq, row_valid, underrun;
  logic [7:0] idata, rd_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] row_q[$];
  logic [7:0] disp[$];
  bit m_rv, m_und;
  int m_chars, m_blen, m_gap, exp_gap;

  always #5 clk = ~clk;

  crt_row_fetch dut (
    .clk(clk), .reset(reset), .ce(ce), .enable(enable),
    .frame_start(frame_start), .row_next(row_next), .chars(chars),
    .burst_cnt(burst_cnt), .burst_space(burst_space), .dack(dack),
    .iowe_n(iowe_n), .idata(idata), .drq(drq), .rd_addr(rd_addr),
    .rd_data(rd_data), .row_valid(row_valid), .underrun(underrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_rv"}, row_valid, m_rv);
    chk({tag, "_und"}, underrun, m_und);
  endtask

  task automatic cfg(input int c, input int bc, input int bs);
    chars       = 7'(c);
    burst_cnt   = 2'(bc);
    burst_space = 3'(bs);
    m_chars = (c == 0) ? 1 : (c > 80) ? 80 : c;
    m_blen  = 1 << bc;
    m_gap   = (bs == 0) ? 0 : 8 * bs - 1;
  endtask

  task automatic swap_m();
    disp = row_q;
    row_q.delete();
    m_rv = 1'b1;
    exp_gap = 0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    row_q.delete();
    m_rv = 1'b0;
    m_und = 1'b0;
    exp_gap = 0;
    chk("frame_drq", drq, 1);
    chk_flags("frame");
  endtask

  task automatic row_pulse();
    row_next = 1'b1;
    step();
    row_next = 1'b0;
    if (row_q.size() == m_chars) swap_m();
    else begin
      m_und = 1'b1;
      m_rv  = 1'b0;
    end
    chk_flags("row_next");
  endtask

  // One DMA byte: wait for drq (ce randomized while waiting), strobe twice
  // with the real byte last, release; rn raises row_next on the commit clk.
  task automatic dma_byte(input logic [7:0] d, input bit rn);
    int cyc = 0;
    int ticks = 0;
    int k;
    while (!drq && cyc < 600) begin
      ce = ($urandom_range(0, 2) != 0);
      if (ce) ticks++;
      @(negedge clk);
      cyc++;
    end
    ce = 1'b0;
    if (!drq) begin
      chk("drq_timeout", 0, 1);
      return;
    end
    if (exp_gap == 0) chk("drq_nogap", cyc, 0);
    else              chk("drq_gap", ticks, exp_gap);
    dack = 1'b1; iowe_n = 1'b0; idata = 8'($urandom);
    step();
    chk("drq_drop", drq, 0);
    idata = d;
    step();
    iowe_n = 1'b1; row_next = rn;
    step();
    row_next = 1'b0; dack = 1'b0;
    row_q.push_back(d);
    k = row_q.size();
    exp_gap = (k < m_chars && (k % m_blen) == 0) ? m_gap : 0;
    if (rn) begin
      if (k == m_chars) swap_m();
      else begin
        m_und = 1'b1;
        m_rv  = 1'b0;
      end
    end
    chk_flags("commit");
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) dma_byte(8'(base + i), 1'b0);
  endtask

  task automatic read_all();
    for (int a = 0; a <= m_chars + 1; a++) begin
      logic [7:0] e;
      rd_addr = 7'(a);
      step();
      e = (m_rv && a < m_chars && a < disp.size()) ? disp[a] : 8'h00;
      chk($sformatf("rd%0d", a), rd_data, e);
    end
  endtask

  task automatic run_random();
    for (int f = 0; f < 5; f++) begin
      int c = ($urandom_range(0, 6) == 0) ? 90 : $urandom_range(0, 20);
      cfg(c, $urandom_range(0, 3), $urandom_range(0, 3));
      frame();
      for (int r = 0; r < 3; r++) begin
        bit done = 1'b0;
        while (!done) begin
          bit lst = (row_q.size() == m_chars - 1);
          dma_byte(8'($urandom), lst && ($urandom_range(0, 1) == 1));
          if (lst) done = 1'b1;
          else if ($urandom_range(0, 15) == 0) row_pulse();
        end
        if (row_q.size() == m_chars) row_pulse();
        read_all();
      end
    end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; enable = 1'b1; frame_start = 1'b0; row_next = 1'b0;
    dack = 1'b0; iowe_n = 1'b1; idata = 8'h00; rd_addr = 7'd0;
    cfg(4, 0, 0);
    m_rv = 1'b0; m_und = 1'b0; exp_gap = 0;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_drq", drq, 0);
    chk("rst_rd", rd_data, 8'h00);
    chk_flags("rst");

    // single-byte bursts, four chars
    frame();
    fill(4, 8'h41);
    repeat (3) step();
    chk("full_drq", drq, 0);
    row_pulse();
    read_all();

    // 4-byte bursts with 7-tick gaps
    cfg(16, 2, 1);
    frame();
    fill(16, 8'h60);
    row_pulse();
    read_all();

    // underrun then late completion
    cfg(80, 3, 0);
    frame();
    fill(10, 8'h00);
    row_pulse();
    fill(70, 8'h0a);
    row_pulse();
    read_all();
    frame();

    // double buffering: A stays visible while B fills
    cfg(8, 1, 0);
    frame();
    fill(8, 8'h10);
    row_pulse();
    for (int i = 0; i < 8; i++) begin
      dma_byte(8'(8'h20 + i), 1'b0);
      read_all();
    end
    row_pulse();
    read_all();

    // stray writes, clamp of 100 to 80, coincident final commit + row_next
    cfg(100, 1, 0);
    frame();
    dack = 1'b0; iowe_n = 1'b0; idata = 8'hee;
    step(); step();
    iowe_n = 1'b1;
    step();
    fill(79, 8'h80);
    dma_byte(8'hcf, 1'b1);
    read_all();
    fill(80, 8'h30);
    dack = 1'b1; iowe_n = 1'b0; idata = 8'hdd;
    step(); step();
    chk("stray_full_drq", drq, 0);
    iowe_n = 1'b1;
    step();
    dack = 1'b0;
    row_pulse();
    read_all();

    // frame_start beats a coincident row_next
    row_next = 1'b1; frame_start = 1'b1;
    step();
    row_next = 1'b0; frame_start = 1'b0;
    row_q.delete(); m_rv = 1'b0; m_und = 1'b0; exp_gap = 0;
    chk("fs_rn_drq", drq, 1);
    chk_flags("fs_rn");

    run_random();

    // abort mid-write: IDLE, row_valid kept, row_next ignored
    cfg(8, 1, 0);
    frame();
    fill(8, 8'h50);
    row_pulse();
    fill(2, 8'h70);
    dack = 1'b1; iowe_n = 1'b0;
    step();
    enable = 1'b0;
    step();
    chk("abort_drq", drq, 0);
    dack = 1'b0; iowe_n = 1'b1;
    repeat (3) step();
    enable = 1'b1;
    repeat (2) step();
    chk("idle_drq", drq, 0);
    row_next = 1'b1;
    step();
    row_next = 1'b0;
    chk_flags("abort");
    read_all();
    frame();

    // reset in the middle of ACK
    cfg(4, 0, 0);
    fill(4, 8'h90);
    row_pulse();
    rd_addr = 7'd0;
    dack = 1'b1; iowe_n = 1'b0;
    step();
    reset = 1'b1;
    step();
    m_rv = 1'b0; m_und = 1'b0;
    chk("rst2_drq", drq, 0);
    chk("rst2_rd", rd_data, 8'h00);
    chk_flags("rst2");
    reset = 1'b0; dack = 1'b0; iowe_n = 1'b1;
    step();
    frame();
    fill(4, 8'ha0);
    row_pulse();
    read_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
